// File: rtl/maze_game_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : maze_game_core                                             |
// | Description : Maze-game engine. Loads a map from an external ROM, moves  |
// |               the player on debounced direction pulses, counts steps,    |
// |               detects win/timeout and scans a red/green LED matrix.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module maze_game_core #(
  parameter int GRID     = 8,
  parameter int MAPS     = 2,
  parameter int STEP_W   = 7,
  parameter int SCAN_DIV = 3,
  localparam int PW = $clog2(GRID),
  localparam int MW = $clog2(MAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_p,
  input  logic              map_next_p,
  input  logic [3:0]        dir_p,
  input  logic              time_zero,
  output logic [MW-1:0]     map_sel,
  output logic [PW-1:0]     rom_row,
  input  logic [GRID-1:0]   rom_data,
  input  logic [2*PW-1:0]   rom_start,
  input  logic [2*PW-1:0]   rom_term,
  output logic [GRID-1:0]   row,
  output logic [GRID-1:0]   r_col,
  output logic [GRID-1:0]   g_col,
  output logic              suc,
  output logic              fail,
  output logic [STEP_W-1:0] step_cnt
);

  localparam int LW = PW + 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] c_LAST     = PW'(GRID - 1);
  localparam logic [LW-1:0] c_LOAD_END = LW'(GRID);
  localparam logic [DW-1:0] c_DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] c_MAP_LAST = MW'(MAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       map_sel_q, map_sel_d;
  logic [LW-1:0]       ld_cnt_q, ld_cnt_d;
  logic [PW-1:0]       pos_r_q, pos_r_d;
  logic [PW-1:0]       pos_c_q, pos_c_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DW-1:0]       div_q, div_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic                suc_q, fail_q;
  logic [GRID-1:0]     row_q, r_col_q, g_col_q;
  logic [GRID-1:0]     row_d, r_col_d, g_col_d;
  logic [GRID-1:0]     map_q [GRID];

  logic                w_cap_en;
  logic [PW-1:0]       w_cap_idx;
  logic                w_mv_req, w_mv_edge, w_mv_ok;
  logic [PW-1:0]       w_tr, w_tc;
  logic                w_at_term;
  logic [GRID-1:0]     w_disp_row;

  // Row N of the ROM arrives one cycle after it was addressed, so the
  // capture lags the load counter by one.
  assign w_cap_en  = (state_q == S_LOAD) && (ld_cnt_q != '0);
  assign w_cap_idx = ld_cnt_q[PW-1:0] - 1'b1;
  assign w_at_term = (pos_r_q == rom_term[2*PW-1:PW]) && (pos_c_q == rom_term[PW-1:0]);

  assign map_sel  = map_sel_q;
  assign rom_row  = (ld_cnt_q != c_LOAD_END) ? ld_cnt_q[PW-1:0] : '0;
  assign row      = row_q;
  assign r_col    = r_col_q;
  assign g_col    = g_col_q;
  assign suc      = suc_q;
  assign fail     = fail_q;
  assign step_cnt = step_q;

  // Pick one requested direction (down>up>left>right) and judge the target.
  always_comb begin
    w_mv_req  = 1'b1;
    w_mv_edge = 1'b0;
    w_tr      = pos_r_q;
    w_tc      = pos_c_q;
    if (dir_p[0]) begin
      w_mv_edge = (pos_r_q == c_LAST);
      w_tr      = pos_r_q + 1'b1;
    end else if (dir_p[1]) begin
      w_mv_edge = (pos_r_q == '0);
      w_tr      = pos_r_q - 1'b1;
    end else if (dir_p[2]) begin
      w_mv_edge = (pos_c_q == '0);
      w_tc      = pos_c_q - 1'b1;
    end else if (dir_p[3]) begin
      w_mv_edge = (pos_c_q == c_LAST);
      w_tc      = pos_c_q + 1'b1;
    end else begin
      w_mv_req  = 1'b0;
    end
    w_mv_ok = w_mv_req && !w_mv_edge && !map_q[w_tr][w_tc];
  end

  // Game FSM next state, map selection, load counter, position and steps.
  always_comb begin
    state_d   = state_q;
    map_sel_d = map_sel_q;
    ld_cnt_d  = '0;
    pos_r_d   = pos_r_q;
    pos_c_d   = pos_c_q;
    step_d    = step_q;
    case (state_q)
      S_IDLE: begin
        if (map_next_p) begin
          map_sel_d = (map_sel_q == c_MAP_LAST) ? '0 : map_sel_q + 1'b1;
        end
        if (start_p) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (start_p) begin
          state_d = S_LOAD;
        end else if (ld_cnt_q == c_LOAD_END) begin
          state_d = S_PLAY;
          pos_r_d = rom_start[2*PW-1:PW];
          pos_c_d = rom_start[PW-1:0];
          step_d  = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (start_p) begin
          state_d = S_LOAD;
        end else if (time_zero) begin
          state_d = S_LOSE;
        end else if (w_at_term) begin
          state_d = S_WIN;
        end else if (w_mv_ok) begin
          pos_r_d = w_tr;
          pos_c_d = w_tc;
          step_d  = (&step_q) ? step_q : step_q + 1'b1;
        end
      end
      S_WIN, S_LOSE: begin
        if (start_p) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan divider, row index and the next matrix drive pattern.
  always_comb begin
    div_d   = div_q + 1'b1;
    idx_d   = idx_q;
    r_col_d = '0;
    g_col_d = '0;
    if (div_q == c_DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == c_LAST) ? '0 : idx_q + 1'b1;
    end
    row_d      = ~(GRID'(1) << idx_d);
    w_disp_row = (w_cap_en && (w_cap_idx == idx_d)) ? rom_data : map_q[idx_d];
    case (state_d)
      S_PLAY: begin
        r_col_d = w_disp_row;
        if (idx_d == pos_r_d) begin
          g_col_d = GRID'(1) << pos_c_d;
        end
      end
      S_WIN:   g_col_d = '1;
      S_LOSE:  r_col_d = '1;
      default: begin
        r_col_d = '0;
        g_col_d = '0;
      end
    endcase
  end

  // Register state, counters, position and all matrix/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      map_sel_q <= '0;
      ld_cnt_q  <= '0;
      pos_r_q   <= '0;
      pos_c_q   <= '0;
      step_q    <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      suc_q     <= 1'b0;
      fail_q    <= 1'b0;
      row_q     <= '1;
      r_col_q   <= '0;
      g_col_q   <= '0;
    end else begin
      state_q   <= state_d;
      map_sel_q <= map_sel_d;
      ld_cnt_q  <= ld_cnt_d;
      pos_r_q   <= pos_r_d;
      pos_c_q   <= pos_c_d;
      step_q    <= step_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      suc_q     <= (state_d == S_WIN);
      fail_q    <= (state_d == S_LOSE);
      row_q     <= row_d;
      r_col_q   <= r_col_d;
      g_col_q   <= g_col_d;
    end
  end

  // Map RAM filled row by row while loading.
  always_ff @(posedge clk) begin
    if (w_cap_en) begin
      map_q[w_cap_idx] <= rom_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_game_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_maze_game_core                                          |
// | Description : Self-checking bench for maze_game_core with a cycle-level  |
// |               game model, directed scenarios and random play.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_maze_game_core;

  localparam int GRID     = 8;
  localparam int MAPS     = 2;
  localparam int STEP_W   = 7;
  localparam int SCAN_DIV = 3;
  localparam int PW       = 3;
  localparam int MW       = 1;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_WIN  = 3;
  localparam int M_LOSE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              start_p = 1'b0;
  logic              map_next_p = 1'b0;
  logic [3:0]        dir_p = 4'b0;
  logic              time_zero = 1'b0;
  logic [MW-1:0]     map_sel;
  logic [PW-1:0]     rom_row;
  logic [GRID-1:0]   rom_data = '0;
  logic [2*PW-1:0]   rom_start;
  logic [2*PW-1:0]   rom_term;
  logic [GRID-1:0]   row, r_col, g_col;
  logic              suc, fail;
  logic [STEP_W-1:0] step_cnt;

  logic [GRID-1:0] rom [MAPS][GRID];
  logic [PW-1:0]   st_r [MAPS];
  logic [PW-1:0]   st_c [MAPS];
  logic [PW-1:0]   tm_r [MAPS];
  logic [PW-1:0]   tm_c [MAPS];

  int n_vec  = 0;
  int n_miss = 0;

  // Model of the game as seen from the pins.
  int              m_mode, m_sel, m_pr, m_pc, m_steps, m_idx, m_div, m_lc;
  bit              m_rst;
  logic [GRID-1:0] m_map [GRID];

  maze_game_core #(
    .GRID(GRID), .MAPS(MAPS), .STEP_W(STEP_W), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start_p(start_p), .map_next_p(map_next_p),
    .dir_p(dir_p), .time_zero(time_zero), .map_sel(map_sel), .rom_row(rom_row),
    .rom_data(rom_data), .rom_start(rom_start), .rom_term(rom_term),
    .row(row), .r_col(r_col), .g_col(g_col), .suc(suc), .fail(fail),
    .step_cnt(step_cnt)
  );

  // Synchronous map ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[map_sel][rom_row];
  assign rom_start = {st_r[map_sel], st_c[map_sel]};
  assign rom_term  = {tm_r[map_sel], tm_c[map_sel]};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic n,
                            input logic [3:0] d, input logic tz);
    int nr, nc;
    if (r) begin
      m_mode = M_IDLE; m_sel = 0; m_pr = 0; m_pc = 0; m_steps = 0;
      m_idx = 0; m_div = 0; m_lc = 0; m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    if (m_div == SCAN_DIV - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % GRID;
    end else begin
      m_div++;
    end
    case (m_mode)
      M_IDLE: begin
        if (n) m_sel = (m_sel + 1) % MAPS;
        if (s) begin m_mode = M_LOAD; m_lc = 0; end
      end
      M_LOAD: begin
        if (s) m_lc = 0;
        else if (m_lc == GRID) begin
          m_mode = M_PLAY; m_pr = st_r[m_sel]; m_pc = st_c[m_sel]; m_steps = 0;
          for (int i = 0; i < GRID; i++) m_map[i] = rom[m_sel][i];
        end else m_lc++;
      end
      M_PLAY: begin
        if (s) begin m_mode = M_LOAD; m_lc = 0; end
        else if (tz) m_mode = M_LOSE;
        else if (m_pr == tm_r[m_sel] && m_pc == tm_c[m_sel]) m_mode = M_WIN;
        else if (d != 4'b0) begin
          nr = m_pr; nc = m_pc;
          if (d[0]) nr++;
          else if (d[1]) nr--;
          else if (d[2]) nc--;
          else nc++;
          if (nr >= 0 && nr < GRID && nc >= 0 && nc < GRID && m_map[nr][nc] == 1'b0) begin
            m_pr = nr; m_pc = nc;
            if (m_steps < (1 << STEP_W) - 1) m_steps++;
          end
        end
      end
      default: if (s) begin m_mode = M_LOAD; m_lc = 0; end
    endcase
  endtask

  task automatic check_outputs();
    logic [GRID-1:0] er, erc, egc;
    er  = m_rst ? '1 : ~(GRID'(1) << m_idx);
    erc = '0;
    egc = '0;
    if (m_mode == M_PLAY) begin
      erc = m_map[m_idx];
      if (m_idx == m_pr) egc = GRID'(1) << m_pc;
    end else if (m_mode == M_WIN) egc = '1;
    else if (m_mode == M_LOSE) erc = '1;
    check_eq("row", 32'(row), 32'(er));
    check_eq("r_col", 32'(r_col), 32'(erc));
    check_eq("g_col", 32'(g_col), 32'(egc));
    check_eq("suc", 32'(suc), 32'(m_mode == M_WIN));
    check_eq("fail", 32'(fail), 32'(m_mode == M_LOSE));
    check_eq("step_cnt", 32'(step_cnt), 32'(m_steps));
    check_eq("map_sel", 32'(map_sel), 32'(m_sel));
    check_eq("rom_row", 32'(rom_row), (m_mode == M_LOAD && m_lc < GRID) ? 32'(m_lc) : 32'd0);
  endtask

  task automatic tick(input logic r, input logic s, input logic n,
                      input logic [3:0] d, input logic tz);
    rst = r; start_p = s; map_next_p = n; dir_p = d; time_zero = tz;
    @(posedge clk);
    model_step(r, s, n, d, tz);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic go(input logic [3:0] d, input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 1'b0, d, 1'b0);
  endtask

  initial begin
    // map 0: start (6,7), term (0,0); bit c = column c
    rom[0][0] = 8'hFE; rom[0][1] = 8'h66; rom[0][2] = 8'h08; rom[0][3] = 8'h24;
    rom[0][4] = 8'h50; rom[0][5] = 8'hAA; rom[0][6] = 8'h00; rom[0][7] = 8'h3C;
    st_r[0] = 3'd6; st_c[0] = 3'd7; tm_r[0] = 3'd0; tm_c[0] = 3'd0;
    // map 1: start (3,3), term (7,7), sparse walls
    rom[1][0] = 8'h00; rom[1][1] = 8'h10; rom[1][2] = 8'h00; rom[1][3] = 8'h00;
    rom[1][4] = 8'h42; rom[1][5] = 8'h00; rom[1][6] = 8'h08; rom[1][7] = 8'h00;
    st_r[1] = 3'd3; st_c[1] = 3'd3; tm_r[1] = 3'd7; tm_c[1] = 3'd7;

    // reset state
    tick(1'b1, 1'b0, 0, 4'b0, 1'b0);
    tick(1'b1, 1'b0, 0, 4'b0, 1'b0);
    idle(2);

    // map selection wraps in IDLE
    tick(1'b0, 1'b0, 1'b1, 4'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 4'b0, 1'b0);

    // load map 0, blocked up, open left, walk to the terminal
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(9);
    go(4'b0010, 1);
    go(4'b0100, 1);
    go(4'b0100, 6);
    go(4'b0010, 6);
    idle(2);
    go(4'b0001, 1);
    go(4'b1000, 1);
    idle(24);

    // timeout wins over a simultaneous move
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(9);
    go(4'b0100, 1);
    tick(1'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
    idle(24);

    // map_next ignored in PLAY, all-direction pulse moves down only
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(9);
    tick(1'b0, 1'b0, 1'b1, 4'b0, 1'b0);
    go(4'b1111, 1);
    idle(4);

    // restart mid-load, then reset mid-PLAY
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(4);
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(9);
    go(4'b0100, 1);
    tick(1'b1, 1'b0, 1'b0, 4'b0, 1'b0);
    idle(5);

    // step counter saturation on map 1
    tick(1'b0, 1'b0, 1'b1, 4'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
    idle(9);
    for (int i = 0; i < 70; i++) begin
      go(4'b0100, 1);
      go(4'b1000, 1);
    end
    idle(3);

    // random play
    for (int i = 0; i < 4000; i++) begin
      logic r, s, n, tz;
      logic [3:0] d;
      r  = ($urandom_range(0, 499) == 0);
      s  = ($urandom_range(0, 79) == 0);
      n  = ($urandom_range(0, 7) == 0);
      d  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
      tz = ($urandom_range(0, 199) == 0);
      if (m_mode != M_PLAY && m_mode != M_LOAD && $urandom_range(0, 9) == 0) s = 1'b1;
      if (m_mode == M_PLAY && m_pr == tm_r[m_sel] && m_pc == tm_c[m_sel]) d = 4'b0;
      tick(r, s, n, d, tz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
